// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word-fall-through receive FIFO.
// The rx line is oversampled and resynchronised. Each frame is deserialised
// LSB first, with optional parity and 1 or 2 stop bits. Good words are
// buffered for a valid/ready consumer.
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_rx           asynchronous serial line, idle high
//   o_data         FIFO head word, meaningful while o_valid = 1
//   o_valid        FIFO non-empty
//   i_ready        pops the head word when o_valid && i_ready
//   o_level        FIFO occupancy
//   o_frame_err    one-cycle pulse: a stop bit was sampled low
//   o_parity_err   one-cycle pulse: parity mismatch, word dropped
//   o_overrun      one-cycle pulse: FIFO full, word dropped
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_rx,
  output logic [DATA_BITS-1:0]              o_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_level,
  output logic                              o_frame_err,
  output logic                              o_parity_err,
  output logic                              o_overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rxs_q, rxs_prev_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q;

  logic tick_c, commit_c, par_ok_c, data_xor_c, pop_c, push_c, full_c;

  assign tick_c = (cnt_q == '0);

  // Receive FSM: each sample is taken when the bit-period counter expires.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    commit_c    = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          state_d = S_START;
          cnt_d   = HALF_M1;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (tick_c) begin
          cnt_d   = FULL_M1;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (tick_c) begin
          cnt_d   = FULL_M1;
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PARITY: begin
        if (tick_c) begin
          cnt_d   = FULL_M1;
          par_d   = rxs_q;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (tick_c) begin
          cnt_d = FULL_M1;
          if (!rxs_q) begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end else if (bit_q == BW'(STOP_BITS - 1)) begin
            commit_c = 1'b1;
            state_d  = S_IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BREAK: begin
        // A held-low line must return high before a new start edge counts.
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Commit decision: parity first, then FIFO space (a same-cycle pop frees a slot).
  assign data_xor_c   = (^shift_q) ^ par_q;
  assign par_ok_c     = (PARITY == 1) ? data_xor_c :
                        (PARITY == 2) ? !data_xor_c : 1'b1;
  assign full_c       = (level_q == LW'(FIFO_DEPTH));
  assign pop_c        = (level_q != '0) && i_ready;
  assign push_c       = commit_c && par_ok_c && (!full_c || pop_c);
  assign parity_err_d = commit_c && !par_ok_c;
  assign overrun_d    = commit_c && par_ok_c && full_c && !pop_c;

  // Synchroniser, FSM registers and FIFO storage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rx_meta_q    <= i_rx;
      rxs_q        <= rx_meta_q;
      rxs_prev_q   <= rxs_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      if (push_c) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_c && !pop_c)      level_q <= level_q + LW'(1);
      else if (!push_c && pop_c) level_q <= level_q - LW'(1);
    end
  end

  assign o_data       = mem_q[rd_ptr_q];
  assign o_valid      = (level_q != '0);
  assign o_level      = level_q;
  assign o_frame_err  = frame_err_q;
  assign o_parity_err = parity_err_q;
  assign o_overrun    = overrun_q;

endmodule
